// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte requesters.
// Define UART_TX_ARB_WDOG_EN to add the per-frame watchdog (wdog_err); otherwise wdog_err is tied low.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_en,
  output logic                 tx_wr,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 arb_idle,
  output logic                 wdog_err
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_WARMUP    = 3'd1,
    S_ARB       = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT_BUSY = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_HOLD      = 3'd6
  } state_t;

  if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYCLES < 2) begin : g_bad_cfg
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and WDOG_CYCLES at least 2");
  end

  state_t               r_state;
  logic [PW-1:0]        r_ptr;
  logic [PW-1:0]        r_owner;
  logic                 r_last;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   r_req_ready;
  logic                 r_tx_en;
  logic                 r_tx_wr;
  logic [7:0]           r_tx_data;
  logic                 r_arb_idle;

  logic [7:0]           w_req_bytes [NUM_REQ];
  logic [PW-1:0]        w_idx;
  logic [PW-1:0]        w_win;
  logic                 w_found;
  logic [PW-1:0]        w_ptr_adv;
  logic                 w_wdog_hit;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
    assign w_req_bytes[gi] = req_data[8*gi +: 8];
  end

  // Scan from the highest offset down so the last hit is the first valid at or after r_ptr.
  always_comb begin
    w_idx   = '0;
    w_win   = '0;
    w_found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = PW'((int'(r_ptr) + k) % NUM_REQ);
      if (req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_ptr_adv = (r_owner == PW'(NUM_REQ - 1)) ? '0 : r_owner + PW'(1);

`ifdef UART_TX_ARB_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] r_wdog_cnt;
  logic          r_wdog_err;

  assign w_wdog_hit = ((r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE)) &&
                      (r_wdog_cnt == WW'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdog_cnt <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)
        r_wdog_cnt <= '0;
      else if ((r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE))
        r_wdog_cnt <= r_wdog_cnt + WW'(1);
      if (w_wdog_hit)
        r_wdog_err <= 1'b1;
    end
  end

  assign wdog_err = r_wdog_err;
`else
  assign w_wdog_hit = 1'b0;
  assign wdog_err   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_OFF;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_last      <= 1'b0;
      r_grant     <= '0;
      r_req_ready <= '0;
      r_tx_en     <= 1'b0;
      r_tx_wr     <= 1'b0;
      r_tx_data   <= 8'h00;
      r_arb_idle  <= 1'b0;
    end else begin
      r_tx_wr     <= 1'b0;
      r_req_ready <= '0;
      case (r_state)
        S_OFF: begin
          r_tx_en <= enable;
          r_grant <= '0;
          r_arb_idle <= ~enable;
          if (enable) r_state <= S_WARMUP;
        end
        S_WARMUP: begin
          r_state    <= S_ARB;
          r_arb_idle <= ~|req_valid;
        end
        S_ARB: begin
          if (!enable) begin
            r_state    <= S_OFF;
            r_tx_en    <= 1'b0;
            r_arb_idle <= 1'b1;
          end else if (w_found) begin
            r_owner    <= w_win;
            r_grant    <= NUM_REQ'(1) << w_win;
            r_state    <= S_ISSUE;
            r_arb_idle <= 1'b0;
          end else begin
            r_arb_idle <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_tx_data   <= w_req_bytes[r_owner];
          r_req_ready <= r_grant;
          r_tx_wr     <= 1'b1;
          r_last      <= req_last[r_owner];
          r_state     <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY, S_WAIT_DONE: begin
          if (w_wdog_hit) begin
            r_grant <= '0;
            r_ptr   <= w_ptr_adv;
            r_state <= S_WARMUP;
          end else if (r_state == S_WAIT_BUSY) begin
            if (tx_busy) r_state <= S_WAIT_DONE;
          end else if (!tx_busy) begin
            // A disabled arbiter lets the frame finish, then gives up the rest of the packet.
            if (!enable || r_last) begin
              r_grant    <= '0;
              r_ptr      <= w_ptr_adv;
              r_state    <= enable ? S_ARB : S_OFF;
              r_tx_en    <= enable;
              r_arb_idle <= ~enable | ~|req_valid;
            end else begin
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!enable) begin
            r_grant    <= '0;
            r_ptr      <= w_ptr_adv;
            r_state    <= S_OFF;
            r_tx_en    <= 1'b0;
            r_arb_idle <= 1'b1;
          end else if (req_valid[r_owner]) begin
            r_state <= S_ISSUE;
          end
        end
        default: r_state <= S_OFF;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign grant     = r_grant;
  assign tx_en     = r_tx_en;
  assign tx_wr     = r_tx_wr;
  assign tx_data   = r_tx_data;
  assign arb_idle  = r_arb_idle;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed steps plus randomized packet loads checked against a
// round-robin packet-order model and a simple frame-timing transmitter model.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           enable = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           tx_en;
  logic           tx_wr;
  logic [7:0]     tx_data;
  logic           tx_busy = 1'b0;
  logic           arb_idle;
  logic           wdog_err;

  uart_tx_arbiter #(.NUM_REQ(N), .WDOG_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant),
    .tx_en(tx_en), .tx_wr(tx_wr), .tx_data(tx_data), .tx_busy(tx_busy),
    .arb_idle(arb_idle), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  // Per-requester byte queues: bit 8 = last, bits 7:0 = data.
  logic [8:0] rq_mem [N][64];
  int rq_head [N];
  int rq_tail [N];
  int m_head  [N];
  int m_ptr;
  logic [7:0] exp_data_q [$];
  int         exp_owner_q [$];
  logic [7:0] cur_byte = 8'h00;
  int tx_delay = 0;
  int tx_left = 0;
  bit tx_stuck = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_pkt(input int r, input int len, input logic [7:0] base);
    for (int b = 0; b < len; b++) begin
      rq_mem[r][rq_tail[r]] = {(b == len - 1), 8'(base + 8'(b))};
      rq_tail[r]++;
    end
  endtask

  // Reference: whole packets served in round-robin order starting at m_ptr.
  task automatic build_expected();
    int owner;
    bit found;
    bit last;
    while (1) begin
      found = 1'b0;
      owner = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && m_head[(m_ptr + k) % N] < rq_tail[(m_ptr + k) % N]) begin
          found = 1'b1;
          owner = (m_ptr + k) % N;
        end
      end
      if (!found) break;
      do begin
        exp_data_q.push_back(rq_mem[owner][m_head[owner]][7:0]);
        exp_owner_q.push_back(owner);
        last = rq_mem[owner][m_head[owner]][8];
        m_head[owner]++;
      end while (!last && m_head[owner] < rq_tail[owner]);
      m_ptr = (owner + 1) % N;
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      if (rq_head[i] < rq_tail[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = rq_mem[i][rq_head[i]][7:0];
        req_last[i]        = rq_mem[i][rq_head[i]][8];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  task automatic tick();
    int eo;
    logic [7:0] ed;
    @(posedge clk);
    #1;
    cycle++;
    if (tx_wr === 1'b1) begin
      if (exp_data_q.size() == 0) begin
        chk("unexpected_wr", {31'd0, tx_wr}, 32'd0);
      end else begin
        ed = exp_data_q.pop_front();
        eo = exp_owner_q.pop_front();
        chk("tx_data", {24'd0, tx_data}, {24'd0, ed});
        chk("grant_at_wr", {28'd0, grant}, 32'(1 << eo));
        chk("req_ready", {28'd0, req_ready}, 32'(1 << eo));
        cur_byte = ed;
        $display("TXN cycle=%0d owner=%0d data=%02h grant=%b", cycle, eo, tx_data, grant);
      end
    end else begin
      chk("ready_quiet", {28'd0, req_ready}, 32'd0);
    end
    if (tx_busy) chk("data_hold", {24'd0, tx_data}, {24'd0, cur_byte});
    for (int i = 0; i < N; i++)
      if (req_ready[i] === 1'b1 && rq_head[i] < rq_tail[i]) rq_head[i]++;
    // Transmitter: busy starts one cycle after the write strobe and lasts 1..6 cycles.
    if (tx_wr === 1'b1 && !tx_stuck) begin
      tx_delay = 1;
      tx_left  = $urandom_range(1, 6);
    end else if (tx_delay > 0) begin
      tx_delay--;
    end else if (tx_left > 0) begin
      tx_left--;
    end
    tx_busy = (tx_delay == 0) && (tx_left > 0);
    drive_reqs();
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    enable   = 1'b0;
    tx_busy  = 1'b0;
    tx_delay = 0;
    tx_left  = 0;
    tx_stuck = 1'b0;
    for (int i = 0; i < N; i++) begin
      rq_head[i] = 0;
      rq_tail[i] = 0;
      m_head[i]  = 0;
    end
    m_ptr = 0;
    exp_data_q.delete();
    exp_owner_q.delete();
    drive_reqs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {12'd0, req_ready, grant, tx_en, tx_wr, tx_data, arb_idle, wdog_err}, 32'd0);
    reset = 1'b0;
  endtask

  task automatic start_arb();
    enable = 1'b1;
    tick();
    tick();
  endtask

  task automatic run_drain(input int budget);
    int n = 0;
    while ((exp_data_q.size() != 0 || grant !== '0 || tx_busy) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(exp_data_q.size()), 32'd0);
    chk("drain_grant", {28'd0, grant}, 32'd0);
  endtask

  initial begin
    int n;
    int t0;

    // Reset, OFF, warm-up, idle arbitration
    do_reset();
    tick();
    tick();
    chk("off_tx_en", {31'd0, tx_en}, 32'd0);
    chk("off_idle", {31'd0, arb_idle}, 32'd1);
    chk("off_grant", {28'd0, grant}, 32'd0);
    enable = 1'b1;
    tick();
    chk("warmup_tx_en", {31'd0, tx_en}, 32'd1);
    repeat (6) tick();
    chk("arb_tx_en", {31'd0, tx_en}, 32'd1);
    chk("arb_idle", {31'd0, arb_idle}, 32'd1);
    chk("arb_no_wr", {31'd0, tx_wr}, 32'd0);

    // Single byte from requester 2
    load_pkt(2, 1, 8'hA5);
    build_expected();
    drive_reqs();
    tick();
    chk("single_grant", {28'd0, grant}, 32'h4);
    chk("single_wr_early", {31'd0, tx_wr}, 32'd0);
    tick();
    chk("single_wr", {31'd0, tx_wr}, 32'd1);
    run_drain(100);
    chk("single_idle", {31'd0, arb_idle}, 32'd1);

    // All four requesters, two single-byte rounds from ptr 0
    do_reset();
    start_arb();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) load_pkt(i, 1, 8'(8'h10 + 8'(i)));
    build_expected();
    drive_reqs();
    run_drain(400);

    // Three-byte packet on requester 1 while 0 and 3 stay valid
    do_reset();
    start_arb();
    load_pkt(0, 1, 8'h20);
    load_pkt(0, 1, 8'h21);
    load_pkt(1, 3, 8'h30);
    load_pkt(3, 1, 8'h40);
    build_expected();
    drive_reqs();
    run_drain(400);

    // Randomized packet loads
    do_reset();
    start_arb();
    for (int round = 0; round < 4; round++) begin
      for (int i = 0; i < N; i++) begin
        n = $urandom_range(0, 3);
        for (int p = 0; p < n; p++) load_pkt(i, $urandom_range(1, 3), 8'($urandom_range(0, 255)));
      end
      build_expected();
      drive_reqs();
      run_drain(1500);
    end

    // enable dropped mid-frame: frame completes, then OFF
    do_reset();
    start_arb();
    load_pkt(0, 1, 8'h55);
    build_expected();
    drive_reqs();
    n = 0;
    do begin
      tick();
      n++;
    end while (tx_busy !== 1'b1 && n < 20);
    chk("busy_seen", {31'd0, tx_busy}, 32'd1);
    enable = 1'b0;
    n = 0;
    while (tx_busy === 1'b1 && n < 20) begin
      chk("frame_tx_en", {31'd0, tx_en}, 32'd1);
      tick();
      n++;
    end
    tick();
    chk("off_after_frame", {31'd0, tx_en}, 32'd0);
    chk("off_after_grant", {28'd0, grant}, 32'd0);
    chk("off_frame_sent", 32'(exp_data_q.size()), 32'd0);

    // Asynchronous reset during WAIT_BUSY
    start_arb();
    load_pkt(1, 1, 8'h66);
    build_expected();
    drive_reqs();
    n = 0;
    do begin
      tick();
      n++;
    end while (tx_wr !== 1'b1 && n < 20);
    chk("wr_before_reset", {31'd0, tx_wr}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_outputs", {12'd0, req_ready, grant, tx_en, tx_wr, tx_data, arb_idle, wdog_err}, 32'd0);
    do_reset();

`ifdef UART_TX_ARB_WDOG_EN
    // Stuck transmitter: watchdog fires 64 cycles after ISSUE and the pointer moves on
    start_arb();
    tx_stuck = 1'b1;
    load_pkt(1, 1, 8'hA1);
    load_pkt(1, 1, 8'hA2);
    load_pkt(2, 1, 8'hB1);
    build_expected();
    drive_reqs();
    n = 0;
    do begin
      tick();
      n++;
    end while (tx_wr !== 1'b1 && n < 20);
    t0 = cycle;
    n = 0;
    while (wdog_err !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("wdog_latency", 32'(cycle - t0), 32'd64);
    chk("wdog_err", {31'd0, wdog_err}, 32'd1);
    chk("wdog_grant", {28'd0, grant}, 32'd0);
    tx_stuck = 1'b0;
    run_drain(400);
    chk("wdog_sticky", {31'd0, wdog_err}, 32'd1);
`else
    start_arb();
    t0 = cycle;
    load_pkt(3, 2, 8'hC0);
    build_expected();
    drive_reqs();
    run_drain(200);
    chk("wdog_tied", {31'd0, wdog_err}, 32'd0);
    chk("run_length", 32'(cycle > t0), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmitter between NUM_REQ byte requesters.
- Sits between client logic and the transmitter's Tx_EN/Tx_WR/Tx_DATA/Tx_BUSY interface.
- Sequences the transmitter: power-up enable, a one-cycle write strobe, data held stable for the whole frame, and completion detection.
- Supports multi-byte packets: a granted requester keeps the grant until its last byte completes.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WDOG_CYCLES, 1024, watchdog limit in clk cycles for a single frame (used only with UART_TX_ARB_WDOG_EN).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- enable  input  1  arbiter/transmitter enable.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
- req_last  input  NUM_REQ  byte is the last byte of its packet.
- req_ready  output  NUM_REQ  one-cycle accept pulse, one-hot.
- grant  output  NUM_REQ  one-hot owner of the transmitter; all zero when no owner.
- tx_en  output  1  to transmitter Tx_EN.
- tx_wr  output  1  to transmitter Tx_WR, one-cycle pulse.
- tx_data  output  8  to transmitter Tx_DATA, registered.
- tx_busy  input  1  from transmitter Tx_BUSY.
- arb_idle  output  1  high in OFF and ARB with no valid request.
- wdog_err  output  1  sticky watchdog flag (tied 0 without the macro).

Behaviour:
- Reset values: all outputs 0, state OFF, rr pointer 0, tx_data 8'h00. Reset mid-frame aborts immediately; the transmitter is reset by the same line.
- All outputs are registered. tx_data changes only in ISSUE and is held until the next ISSUE, because the transmitter reads Tx_DATA combinationally for the whole frame.
- OFF: tx_en=0, grant=0. enable=1 -> WARMUP.
- WARMUP: tx_en=1 for one cycle so the transmitter reaches its ready state; then -> ARB.
- ARB:
  - Search from index ptr upward, wrapping modulo NUM_REQ; the first req_valid wins.
  - Winner is registered into grant; -> ISSUE the next cycle.
  - No valid request: stay in ARB.
  - enable=0: -> OFF.
- ISSUE (one cycle):
  - tx_data <= req_data of the owner; req_ready[owner] pulses; tx_wr=1.
  - Capture req_last of the owner into last_q.
  - -> WAIT_BUSY.
- WAIT_BUSY: tx_wr=0; wait for tx_busy=1, then -> WAIT_DONE.
- WAIT_DONE: wait for tx_busy=0, then:
  - last_q=0 -> HOLD.
  - last_q=1 -> ptr <= owner+1 mod NUM_REQ; grant cleared; -> ARB.
- HOLD: grant kept.
  - req_valid[owner]=1 -> ISSUE.
  - enable=0 -> OFF; the packet is abandoned and the pointer advances.
  - Other requesters cannot preempt.
- enable deasserted during WAIT_BUSY/WAIT_DONE: the current frame completes. Exit then goes to OFF instead of ARB/HOLD; the pointer advances.
- Timing:
  - Latency from req_valid rising in ARB to tx_wr: 2 cycles (grant cycle, then ISSUE).
  - Back-to-back bytes of one packet: one HOLD cycle between tx_busy falling and the next tx_wr.
- Simultaneous requests: strictly round-robin; each of NUM_REQ continuously valid requesters is served once per NUM_REQ packets.
- Requesters must hold req_data/req_last stable while req_valid=1 and not yet accepted. Dropping req_valid before accept in ARB simply loses arbitration; no error.
- State encoding: 3 bits (OFF, WARMUP, ARB, ISSUE, WAIT_BUSY, WAIT_DONE, HOLD).

Optional Feature:
- Macro: UART_TX_ARB_WDOG_EN.
- Defined:
  - A counter clears in ISSUE and increments in WAIT_BUSY/WAIT_DONE.
  - Reaching WDOG_CYCLES sets wdog_err (sticky until reset), clears grant, advances the pointer and returns to WARMUP.
  - Width is clog2(WDOG_CYCLES+1).
- Undefined: no counter; wdog_err tied 0; WAIT states wait indefinitely.

Test Plan:
- Reset then enable=1, no requests -> tx_en=1 from the cycle after enable; state ARB; arb_idle=1; tx_wr never pulses.
- Single byte: req_valid[2]=1, data 8'hA5, last=1 -> grant=4'b0100 one cycle later; next cycle tx_wr=1, req_ready[2]=1, tx_data=8'hA5; tx_data held until tx_busy falls; then grant=0.
- All four requesting single bytes 8'h10..8'h13 from ptr=0 -> tx_data order 10,11,12,13, then 10 again; each req_ready exactly once per round.
- Packet: req1 sends 3 bytes (last on the third) while req0 and req3 stay valid -> grant stays 4'b0010 for all 3 frames; then the next grant goes to req3 (ptr=2 search).
- Mid-frame: enable=0 during WAIT_DONE -> frame completes, then state OFF, tx_en=0; asserting reset during WAIT_BUSY clears all outputs immediately.
- With UART_TX_ARB_WDOG_EN, WDOG_CYCLES=64: tx_busy stuck 0 after tx_wr -> wdog_err=1 at cycle 64 after ISSUE; grant=0; next grant goes to the following requester.
